// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signal bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_last;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    grant;
  logic [DW-1:0]       tx_data;
  logic                tx_wr;
  logic                tx_busy;
  logic                timeout_err;

  // Requesters plus transmitter side, as seen from outside the arbiter
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_data, tx_wr, timeout_err
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_data, tx_wr, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin burst arbiter sharing one UART transmitter
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_n;
  logic [N_REQ-1:0] grant_q, grant_n;
  logic [PW-1:0]    owner_q, owner_n;
  logic [PW-1:0]    ptr_q, ptr_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             last_q, last_n;
  logic [DW-1:0]    tx_data_q, tx_data_n;
  logic             tx_wr_q, tx_wr_n;
  logic             tout_q, tout_n;

  logic             sel_found;
  logic [PW-1:0]    sel_idx;
  logic [N_REQ-1:0] sel_onehot;
  int               pos;
  logic [DW-1:0]    owner_data;
  logic             owner_valid;
  logic             owner_last;
  logic             accept;
  logic [PW-1:0]    next_ptr;

  assign owner_valid = bus.req_valid[owner_q];
  assign owner_last  = bus.req_last[owner_q];
  assign accept      = (state == GRANT) && owner_valid && !bus.tx_busy;
  assign next_ptr    = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + PW'(1);

  // Ready depends only on registered state and tx_busy, never on req_valid
  assign bus.req_ready   = (state == GRANT && !bus.tx_busy) ? grant_q : '0;
  assign bus.grant       = grant_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_wr       = tx_wr_q;
  assign bus.timeout_err = tout_q;

  // Pick the first valid requester at or after ptr; scanning from the far end lets the nearest win
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    pos        = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos = int'(ptr_q) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (bus.req_valid[pos[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = pos[PW-1:0];
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      sel_onehot[j] = (sel_idx == PW'(j));
    end
  end

  // Select the owner's data lane with constant slices
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == PW'(i)) owner_data = bus.req_data[i*DW +: DW];
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_n   = state;
    grant_n   = grant_q;
    owner_n   = owner_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    last_n    = last_q;
    tx_data_n = tx_data_q;
    tx_wr_n   = 1'b0;
    tout_n    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          grant_n = sel_onehot;
          owner_n = sel_idx;
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          tx_data_n = owner_data;
          last_n    = owner_last;
          cnt_n     = '0;
          tx_wr_n   = 1'b1;
          state_n   = GAP;
        end else if (!owner_valid) begin
          // Owner idle inside its burst; a busy-stalled owner does not count
          if (cnt_q == CW'(TIMEOUT - 1)) begin
            tout_n  = 1'b1;
            grant_n = '0;
            ptr_n   = next_ptr;
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt_q + CW'(1);
          end
        end
      end
      GAP: begin
        // The strobe cycle gives tx_busy time to rise before the next byte is offered
        if (last_q) begin
          grant_n = '0;
          ptr_n   = next_ptr;
          state_n = IDLE;
        end else begin
          state_n = GRANT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset abandons any burst in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      last_q    <= 1'b0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state     <= state_n;
      grant_q   <= grant_n;
      owner_q   <= owner_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
      last_q    <= last_n;
      tx_data_q <= tx_data_n;
      tx_wr_q   <= tx_wr_n;
      tout_q    <= tout_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N), .DW(W)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .DW(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { int cyc; logic [3:0] g; logic [7:0] d; } obs_t;

  logic [11:0] exp_q[$];
  obs_t        obs_q[$];
  logic [8:0]  lane_q[N][$];
  logic [3:0]  acc = '0;
  int          cyc = 0;
  int          busy_left = 0;
  int          busy_cyc = 0;
  logic        busy_force = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  assign bus.tx_busy = busy_force || (busy_left != 0);

  // Cycle counter and record of which lanes were accepted on this edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    acc <= bus.req_valid & bus.req_ready;
  end

  // Lane drivers: retire accepted bytes, present the head of each lane queue
  always @(negedge clk) begin
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
      if (lane_q[i].size() > 0) begin
        v[i]       = 1'b1;
        l[i]       = lane_q[i][0][8];
        d[i*W +: W] = lane_q[i][0][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  end

  // Transmitter model and strobe monitor
  always @(negedge clk) begin
    obs_t o;
    if (!rst) busy_left = 0;
    else if (bus.tx_wr && busy_cyc > 0) busy_left = busy_cyc;
    else if (busy_left > 0) busy_left = busy_left - 1;
    if (bus.tx_wr) begin
      o.cyc = cyc; o.g = bus.grant; o.d = bus.tx_data;
      obs_q.push_back(o);
    end
  end

  task automatic send(input int lane, input logic [7:0] data, input logic last);
    lane_q[lane].push_back({last, data});
  endtask

  task automatic expect_byte(input int lane, input logic [7:0] data);
    logic [3:0] oh;
    oh = 4'b0001 << lane;
    exp_q.push_back({oh, data});
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    exp_q.delete();
    obs_q.delete();
    busy_force = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_obs(input int n, input int limit, output bit ok);
    int k;
    k = 0;
    while (obs_q.size() < n && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++; if (bus.grant !== 4'b0) $display("FAIL reset_grant: got %b want 0000", bus.grant); else n_pass++;
    n_checks++; if (bus.req_ready !== 4'b0) $display("FAIL reset_ready: got %b want 0000", bus.req_ready); else n_pass++;
    n_checks++; if (bus.tx_wr !== 1'b0) $display("FAIL reset_tx_wr: got %b want 0", bus.tx_wr); else n_pass++;
    n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); else n_pass++;
    n_checks++; if (bus.timeout_err !== 1'b0) $display("FAIL reset_timeout_err: got %b want 0", bus.timeout_err); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    obs_t o, p;
    logic [11:0] e;
    apply_reset();
    busy_cyc = 10;
    @(negedge clk); #1;
    send(2, 8'h41, 1'b0); send(2, 8'h42, 1'b0); send(2, 8'h43, 1'b1);
    expect_byte(2, 8'h41); expect_byte(2, 8'h42); expect_byte(2, 8'h43);
    @(negedge clk); #1;
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL single_grant_early: got %b want 0000", bus.grant); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (bus.grant !== 4'b0100) $display("FAIL single_grant: got %b want 0100", bus.grant); else n_pass++;
    wait_obs(3, 200, ok);
    n_checks++; if (!ok) $display("FAIL single_wait: got %0d strobes want 3", obs_q.size()); else n_pass++;
    if (ok) begin
      n_checks++;
      if (obs_q[1].cyc - obs_q[0].cyc < 10) $display("FAIL single_spacing: got %0d cycles want >= 10", obs_q[1].cyc - obs_q[0].cyc);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o.g !== e[11:8] || o.d !== e[7:0])
          $display("FAIL single_byte%0d: got grant %b data %h want grant %b data %h", k, o.g, o.d, e[11:8], e[7:0]);
        else n_pass++;
      end
    end
    @(negedge clk); #1;
    n_checks++; if (bus.grant !== 4'b0000) $display("FAIL single_release: got %b want 0000", bus.grant); else n_pass++;
    send(0, 8'hA0, 1'b1); send(3, 8'hA3, 1'b1);
    expect_byte(3, 8'hA3); expect_byte(0, 8'hA0);
    wait_obs(2, 200, ok);
    n_checks++; if (!ok) $display("FAIL single_ptr_wait: got %0d strobes want 2", obs_q.size()); else n_pass++;
    if (ok) begin
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); p = obs_q.pop_front();
        n_checks++;
        if (p.g !== e[11:8] || p.d !== e[7:0])
          $display("FAIL single_ptr%0d: got grant %b data %h want grant %b data %h", k, p.g, p.d, e[11:8], e[7:0]);
        else n_pass++;
      end
    end
    busy_cyc = 0;
  endtask

  task automatic test_fairness();
    bit ok;
    obs_t o;
    logic [11:0] e;
    apply_reset();
    @(negedge clk); #1;
    for (int i = 0; i < N; i++) begin
      send(i, 8'h10 + 8'(i), 1'b1);
      send(i, 8'h20 + 8'(i), 1'b1);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) expect_byte(i, 8'h10 * 8'(r + 1) + 8'(i));
    wait_obs(8, 100, ok);
    n_checks++; if (!ok) $display("FAIL fair_wait: got %0d strobes want 8", obs_q.size()); else n_pass++;
    if (ok) begin
      n_checks++;
      if (obs_q[1].cyc - obs_q[0].cyc != 3) $display("FAIL fair_burst_gap: got %0d cycles want 3", obs_q[1].cyc - obs_q[0].cyc);
      else n_pass++;
      for (int k = 0; k < 8; k++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o.g !== e[11:8] || o.d !== e[7:0])
          $display("FAIL fair_order%0d: got grant %b data %h want grant %b data %h", k, o.g, o.d, e[11:8], e[7:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_burst_lock();
    bit lock_bad;
    int g1_cyc;
    int k;
    obs_t o;
    logic [11:0] e;
    apply_reset();
    lock_bad = 1'b0;
    g1_cyc = -1;
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      send(0, 8'hB0 + 8'(i), i == 4);
      expect_byte(0, 8'hB0 + 8'(i));
    end
    @(negedge clk); #1;
    send(1, 8'hC1, 1'b1);
    expect_byte(1, 8'hC1);
    k = 0;
    while (obs_q.size() < 6 && k < 100) begin
      @(negedge clk); #1;
      if (bus.req_ready[1] && obs_q.size() < 5) lock_bad = 1'b1;
      if (bus.grant == 4'b0010 && g1_cyc < 0) g1_cyc = cyc;
      k++;
    end
    n_checks++; if (obs_q.size() < 6) $display("FAIL lock_wait: got %0d strobes want 6", obs_q.size()); else n_pass++;
    n_checks++; if (lock_bad) $display("FAIL lock_ready1: got req_ready[1]=1 during burst want 0"); else n_pass++;
    if (obs_q.size() >= 6) begin
      n_checks++;
      if (g1_cyc != obs_q[4].cyc + 2) $display("FAIL lock_regrant: got cycle %0d want %0d", g1_cyc, obs_q[4].cyc + 2);
      else n_pass++;
      n_checks++;
      if (obs_q[1].cyc - obs_q[0].cyc != 2) $display("FAIL lock_rate: got %0d cycles want 2", obs_q[1].cyc - obs_q[0].cyc);
      else n_pass++;
      for (int j = 0; j < 6; j++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o.g !== e[11:8] || o.d !== e[7:0])
          $display("FAIL lock_byte%0d: got grant %b data %h want grant %b data %h", j, o.g, o.d, e[11:8], e[7:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int gap_c, err_c, pulses;
    logic [3:0] err_g;
    obs_t o;
    logic [11:0] e;
    apply_reset();
    @(negedge clk); #1;
    send(3, 8'h77, 1'b0);
    expect_byte(3, 8'h77);
    wait_obs(1, 20, ok);
    n_checks++; if (!ok) $display("FAIL to_wait: got %0d strobes want 1", obs_q.size()); else n_pass++;
    gap_c = ok ? obs_q[0].cyc : 0;
    err_c = -1; err_g = 4'bxxxx; pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (bus.timeout_err) begin
        pulses++;
        if (err_c < 0) begin err_c = cyc; err_g = bus.grant; end
      end
    end
    n_checks++; if (pulses != 1) $display("FAIL to_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (err_c != gap_c + TO + 1) $display("FAIL to_cycle: got %0d want %0d", err_c, gap_c + TO + 1); else n_pass++;
    n_checks++; if (err_g !== 4'b0000) $display("FAIL to_grant: got %b want 0000", err_g); else n_pass++;
    if (ok) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.g !== e[11:8] || o.d !== e[7:0])
        $display("FAIL to_byte: got grant %b data %h want grant %b data %h", o.g, o.d, e[11:8], e[7:0]);
      else n_pass++;
    end
    send(2, 8'hD2, 1'b1); send(0, 8'hD0, 1'b1);
    expect_byte(0, 8'hD0); expect_byte(2, 8'hD2);
    wait_obs(2, 50, ok);
    n_checks++; if (!ok) $display("FAIL to_next_wait: got %0d strobes want 2", obs_q.size()); else n_pass++;
    if (ok) begin
      for (int k = 0; k < 2; k++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o.g !== e[11:8] || o.d !== e[7:0])
          $display("FAIL to_next%0d: got grant %b data %h want grant %b data %h", k, o.g, o.d, e[11:8], e[7:0]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok, bad_rdy, bad_wr, bad_to;
    int rel;
    obs_t o;
    logic [11:0] e;
    apply_reset();
    busy_force = 1'b1;
    bad_rdy = 1'b0; bad_wr = 1'b0; bad_to = 1'b0;
    @(negedge clk); #1;
    send(1, 8'h5A, 1'b1);
    expect_byte(1, 8'h5A);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      if (bus.req_ready != 4'b0) bad_rdy = 1'b1;
      if (bus.tx_wr) bad_wr = 1'b1;
      if (bus.timeout_err) bad_to = 1'b1;
    end
    n_checks++; if (bad_rdy) $display("FAIL bp_ready: got nonzero req_ready want 0000"); else n_pass++;
    n_checks++; if (bad_wr) $display("FAIL bp_tx_wr: got tx_wr=1 want 0"); else n_pass++;
    n_checks++; if (bad_to) $display("FAIL bp_timeout: got timeout_err=1 want 0"); else n_pass++;
    n_checks++; if (bus.grant !== 4'b0010) $display("FAIL bp_grant: got %b want 0010", bus.grant); else n_pass++;
    @(negedge clk);
    busy_force = 1'b0;
    rel = cyc;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b want 0010", bus.req_ready); else n_pass++;
    wait_obs(1, 10, ok);
    n_checks++; if (!ok) $display("FAIL bp_wait: got %0d strobes want 1", obs_q.size()); else n_pass++;
    if (ok) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o.cyc != rel + 1) $display("FAIL bp_strobe_cycle: got %0d want %0d", o.cyc, rel + 1); else n_pass++;
      n_checks++;
      if (o.g !== e[11:8] || o.d !== e[7:0])
        $display("FAIL bp_byte: got grant %b data %h want grant %b data %h", o.g, o.d, e[11:8], e[7:0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok, found;
    int k;
    obs_t o;
    logic [11:0] e;
    apply_reset();
    @(negedge clk); #1;
    send(1, 8'h61, 1'b1);
    expect_byte(1, 8'h61);
    wait_obs(1, 20, ok);
    n_checks++; if (!ok) $display("FAIL rm_pre_wait: got %0d strobes want 1", obs_q.size()); else n_pass++;
    if (ok) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o.g !== e[11:8] || o.d !== e[7:0])
        $display("FAIL rm_pre_byte: got grant %b data %h want grant %b data %h", o.g, o.d, e[11:8], e[7:0]);
      else n_pass++;
    end
    send(2, 8'h31, 1'b0); send(2, 8'h32, 1'b0); send(2, 8'h33, 1'b1);
    found = 1'b0; k = 0;
    while (!found && k < 30) begin
      @(negedge clk); #1;
      if (bus.tx_wr && bus.grant == 4'b0100) found = 1'b1;
      k++;
    end
    n_checks++; if (!found) $display("FAIL rm_gap_wait: got no GAP for lane 2 want one"); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.grant, bus.req_ready, bus.tx_wr, bus.timeout_err} !== 10'b0)
      $display("FAIL rm_async_ctrl: got grant %b ready %b wr %b err %b want all 0", bus.grant, bus.req_ready, bus.tx_wr, bus.timeout_err);
    else n_pass++;
    n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL rm_async_data: got %h want 00", bus.tx_data); else n_pass++;
    for (int i = 0; i < N; i++) lane_q[i].delete();
    exp_q.delete();
    obs_q.delete();
    send(1, 8'h71, 1'b1); send(3, 8'h73, 1'b1);
    expect_byte(1, 8'h71); expect_byte(3, 8'h73);
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (bus.grant !== 4'b0010) $display("FAIL rm_regrant: got %b want 0010", bus.grant); else n_pass++;
    wait_obs(2, 50, ok);
    n_checks++; if (!ok) $display("FAIL rm_wait: got %0d strobes want 2", obs_q.size()); else n_pass++;
    if (ok) begin
      for (int j = 0; j < 2; j++) begin
        e = exp_q.pop_front(); o = obs_q.pop_front();
        n_checks++;
        if (o.g !== e[11:8] || o.d !== e[7:0])
          $display("FAIL rm_byte%0d: got grant %b data %h want grant %b data %h", j, o.g, o.d, e[11:8], e[7:0]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_burst_lock();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
